age_issue_queue: RTL and testbench

AGE_ISSUE_QUEUE -- requirements
Module: age_issue_queue

---
 rtl/age_issue_queue_pkg.sv | 33 +++
 rtl/age_issue_queue_if.sv | 32 +++
 rtl/age_issue_queue_age_select.sv | 34 +++
 rtl/mwpram.sv | 30 +++
 rtl/age_issue_queue.sv | 196 +++++++++++++++++++
 tb/tb_age_issue_queue.sv | 451 ++++++++++++++++++++++++++++++++++++++++
 6 files changed

// File: rtl/age_issue_queue_pkg.sv
// Shared types for the age-ordered issue queue.
// Provides the issue/execute bundle layouts, the 5-bit FU class encoding and
// the default per-port FU class mask.
package age_issue_queue_pkg;

    localparam int unsigned PRW = 6;  // physical register address width
    localparam int unsigned FUW = 5;  // FU class mask width

    typedef logic [FUW-1:0] fu_t;

    localparam fu_t FU_ALU = 5'b00001;
    localparam fu_t FU_MUL = 5'b00010;
    localparam fu_t FU_LSU = 5'b00100;
    localparam fu_t FU_BR  = 5'b01000;
    localparam fu_t FU_FP  = 5'b10000;

    // opid[15] is the lane valid bit in both bundle types.
    typedef struct packed {
        logic [15:0]          opid;
        fu_t                  fu;
        logic [1:0][PRW-1:0]  prsa;
        logic [PRW-1:0]       prda;
    } iss_bundle_t;

    typedef struct packed {
        logic [15:0]    opid;
        logic [PRW-1:0] prda;
    } exe_bundle_t;

    // Port 0 and 1 serve ALU ops, port 2 serves LSU ops.
    localparam logic [2:0][FUW-1:0] PORT_FU_DEFAULT = {FU_LSU, FU_ALU, FU_ALU};

endpackage

// File: rtl/age_issue_queue_if.sv
// Bundle interface of the issue queue.
// master: rename/execute/consumer side; slave: the queue.
//   redir, fu_ready, exe_bundle, ren_bundle, busy_resp, issue -> queue
//   ready, iss_bundle, count                                  <- queue
interface age_issue_queue_if
    import age_issue_queue_pkg::*;
#(
    parameter int unsigned rwd  = 4,
    parameter int unsigned pwd  = 3,
    parameter int unsigned ewd  = 4,
    parameter int unsigned iqsz = 16
) ();
    logic                       redir;
    fu_t                        fu_ready;
    exe_bundle_t [ewd-1:0]      exe_bundle;
    iss_bundle_t [rwd-1:0]      ren_bundle;
    logic [rwd-1:0][1:0]        busy_resp;
    logic [rwd-1:0]             ready;
    iss_bundle_t [pwd-1:0]      iss_bundle;
    logic [pwd-1:0]             issue;
    logic [$clog2(iqsz):0]      count;

    modport master (
        output redir, fu_ready, exe_bundle, ren_bundle, busy_resp, issue,
        input  ready, iss_bundle, count
    );

    modport slave (
        input  redir, fu_ready, exe_bundle, ren_bundle, busy_resp, issue,
        output ready, iss_bundle, count
    );
endinterface

// File: rtl/age_issue_queue_age_select.sv
// Oldest-requester picker over an age matrix.
// Ports: req (candidates), excl (already taken by earlier ports),
//        age[i][j] = 1 when entry i is older than entry j,
//        gnt (one-hot winner), vld (any winner), idx (winner index).
module age_select #(
    parameter int unsigned n  = 16,
    parameter int unsigned iw = $clog2(n)
) (
    input  logic [n-1:0]          req,
    input  logic [n-1:0]          excl,
    input  logic [n-1:0][n-1:0]   age,
    output logic [n-1:0]          gnt,
    output logic                  vld,
    output logic [iw-1:0]         idx
);
    logic [n-1:0] cand;

    always_comb begin
        cand = req & ~excl;
        gnt  = '0;
        idx  = '0;
        // Winner is the candidate older than every other candidate.
        for (int i = 0; i < n; i++) begin
            gnt[i] = cand[i];
            for (int j = 0; j < n; j++) begin
                if (j != i && cand[j] && !age[i][j]) gnt[i] = 1'b0;
            end
        end
        for (int i = 0; i < n; i++) begin
            if (gnt[i]) idx = iw'(i);
        end
        vld = |cand;
    end
endmodule

// File: rtl/mwpram.sv
// Multi-write, multi-read register-file RAM.
// Ports: clk; we/waddr/wdata per write port (synchronous);
//        raddr/rdata per read port (combinational read).
// Write ports must target distinct addresses in one cycle.
module mwpram #(
    parameter int unsigned depth = 16,
    parameter int unsigned width = 8,
    parameter int unsigned nw    = 1,
    parameter int unsigned nr    = 1,
    parameter int unsigned aw    = $clog2(depth)
) (
    input  logic                      clk,
    input  logic [nw-1:0]             we,
    input  logic [nw-1:0][aw-1:0]     waddr,
    input  logic [nw-1:0][width-1:0]  wdata,
    input  logic [nr-1:0][aw-1:0]     raddr,
    output logic [nr-1:0][width-1:0]  rdata
);
    logic [width-1:0] mem [depth];

    always_ff @(posedge clk) begin
        for (int w = 0; w < nw; w++) begin
            if (we[w]) mem[waddr[w]] <= wdata[w];
        end
    end

    always_comb begin
        for (int r = 0; r < nr; r++) rdata[r] = mem[raddr[r]];
    end
endmodule

// File: rtl/age_issue_queue.sv
// Age-ordered issue queue.
// Ports: clk, rst (sync, active high), bus (slave modport):
//   enqueue up to rwd ops per cycle as a lane prefix, wake sources from
//   exe_bundle, issue the oldest ready op per port with combinational select.
module age_issue_queue
    import age_issue_queue_pkg::*;
#(
    parameter int unsigned rwd  = 4,
    parameter int unsigned pwd  = 3,
    parameter int unsigned ewd  = 4,
    parameter int unsigned iqsz = 16,
    parameter logic [pwd-1:0][FUW-1:0] port_fu = PORT_FU_DEFAULT
) (
    input logic              clk,
    input logic              rst,
    age_issue_queue_if.slave bus
);
    localparam int unsigned IW = $clog2(iqsz);
    localparam int unsigned CW = IW + 1;

    logic [iqsz-1:0]                occ_q, occ_d;
    logic [iqsz-1:0][1:0]           busy_q, busy_d, busy_fwd;
    logic [iqsz-1:0][1:0][PRW-1:0]  src_q, src_d;
    fu_t  [iqsz-1:0]                fu_q, fu_d;
    logic [iqsz-1:0][iqsz-1:0]      age_q, age_d;
    logic [CW-1:0]                  count_q, count_d;

    logic                           blk;
    logic [rwd-1:0]                 acc;
    logic [rwd-1:0][IW-1:0]         widx;
    logic [iqsz-1:0]                new_mask;
    logic [pwd-1:0][iqsz-1:0]       rdy, gnt;
    logic [pwd:0][iqsz-1:0]         excl;
    logic [pwd-1:0]                 sel_vld;
    logic [pwd-1:0][IW-1:0]         sel_idx;
    logic [pwd-1:0][$bits(iss_bundle_t)-1:0] rdata;

    function automatic logic woken(input exe_bundle_t [ewd-1:0] exe,
                                   input logic [PRW-1:0] a);
        woken = 1'b0;
        for (int k = 0; k < ewd; k++) begin
            if (exe[k].opid[15] && exe[k].prda == a) woken = 1'b1;
        end
    endfunction

    // Outputs are suppressed during reset and redirect cycles.
    assign blk = rst | bus.redir;

    // Same-cycle wakeup forwarding of stored busy bits.
    always_comb begin
        for (int e = 0; e < iqsz; e++) begin
            for (int s = 0; s < 2; s++) begin
                busy_fwd[e][s] = busy_q[e][s] & ~woken(bus.exe_bundle, src_q[e][s]);
            end
        end
    end

    always_comb begin
        for (int p = 0; p < pwd; p++) begin
            for (int e = 0; e < iqsz; e++) begin
                rdy[p][e] = occ_q[e] & ~busy_fwd[e][0] & ~busy_fwd[e][1] & ~blk &
                            (|(fu_q[e] & port_fu[p] & bus.fu_ready));
            end
        end
    end

    // Each port excludes the entries picked by lower-numbered ports.
    always_comb begin
        excl[0] = '0;
        for (int p = 0; p < pwd; p++) excl[p+1] = excl[p] | gnt[p];
    end

    for (genvar p = 0; p < pwd; p++) begin : g_port
        age_select #(.n(iqsz)) u_sel (
            .req  (rdy[p]),
            .excl (excl[p]),
            .age  (age_q),
            .gnt  (gnt[p]),
            .vld  (sel_vld[p]),
            .idx  (sel_idx[p])
        );
    end

    // Prefix enqueue into the lowest free entries; entries freed this cycle
    // stay occupied in occ_q and are therefore not reused until next cycle.
    always_comb begin
        logic          ok;
        logic          found;
        logic [CW-1:0] room;
        room     = CW'(iqsz) - count_q;
        ok       = ~blk;
        acc      = '0;
        widx     = '0;
        new_mask = '0;
        for (int l = 0; l < rwd; l++) begin
            ok     = ok & bus.ren_bundle[l].opid[15] & (CW'(l) < room);
            acc[l] = ok;
            found  = 1'b0;
            for (int e = 0; e < iqsz; e++) begin
                if (ok && !found && !occ_q[e] && !new_mask[e]) begin
                    widx[l] = IW'(e);
                    found   = 1'b1;
                end
            end
            if (ok) new_mask[widx[l]] = 1'b1;
        end
    end

    always_comb begin
        logic [CW-1:0] n_enq;
        logic [CW-1:0] n_iss;
        occ_d  = occ_q;
        busy_d = busy_fwd;
        src_d  = src_q;
        fu_d   = fu_q;
        age_d  = age_q;
        n_enq  = '0;
        n_iss  = '0;
        for (int p = 0; p < pwd; p++) begin
            if (bus.issue[p] && sel_vld[p]) begin
                occ_d = occ_d & ~gnt[p];
                n_iss = n_iss + CW'(1);
            end
        end
        for (int l = 0; l < rwd; l++) begin
            if (acc[l]) begin
                occ_d[widx[l]] = 1'b1;
                src_d[widx[l]] = bus.ren_bundle[l].prsa;
                fu_d[widx[l]]  = bus.ren_bundle[l].fu;
                for (int s = 0; s < 2; s++) begin
                    busy_d[widx[l]][s] = bus.busy_resp[l][s] &
                        ~woken(bus.exe_bundle, bus.ren_bundle[l].prsa[s]);
                end
                // New entry is younger than everything already resident.
                for (int j = 0; j < iqsz; j++) begin
                    age_d[widx[l]][j] = 1'b0;
                    age_d[j][widx[l]] = ~new_mask[j];
                end
                n_enq = n_enq + CW'(1);
            end
        end
        // Within one cycle a lower lane is older.
        for (int l = 0; l < rwd; l++) begin
            for (int m = l + 1; m < rwd; m++) begin
                if (acc[l] && acc[m]) age_d[widx[l]][widx[m]] = 1'b1;
            end
        end
        count_d = count_q + n_enq - n_iss;
        if (bus.redir) begin
            occ_d   = '0;
            busy_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            occ_q   <= '0;
            busy_q  <= '0;
            src_q   <= '0;
            fu_q    <= '0;
            age_q   <= '0;
            count_q <= '0;
        end else begin
            occ_q   <= occ_d;
            busy_q  <= busy_d;
            src_q   <= src_d;
            fu_q    <= fu_d;
            age_q   <= age_d;
            count_q <= count_d;
        end
    end

    mwpram #(
        .depth (iqsz),
        .width ($bits(iss_bundle_t)),
        .nw    (rwd),
        .nr    (pwd)
    ) u_ram (
        .clk   (clk),
        .we    (acc),
        .waddr (widx),
        .wdata (bus.ren_bundle),
        .raddr (sel_idx),
        .rdata (rdata)
    );

    assign bus.ready = acc;
    assign bus.count = count_q;

    always_comb begin
        for (int p = 0; p < pwd; p++) begin
            bus.iss_bundle[p] = sel_vld[p] ? iss_bundle_t'(rdata[p]) : '0;
        end
    end
endmodule

// File: tb/tb_age_issue_queue.sv
module tb_age_issue_queue;
    import age_issue_queue_pkg::*;

    localparam int RWD = 4, PWD = 3, EWD = 4, IQSZ = 16;
    localparam fu_t ALU = 5'b00001, MUL = 5'b00010, LSU = 5'b00100;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    age_issue_queue_if #(.rwd(RWD), .pwd(PWD), .ewd(EWD), .iqsz(IQSZ)) bus ();

    age_issue_queue #(.rwd(RWD), .pwd(PWD), .ewd(EWD), .iqsz(IQSZ)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp  = 0;
    int n_fail = 0;
    int opid_n = 1;
    logic [PWD-1:0][4:0] pfu = {5'b00100, 5'b00001, 5'b00001};

    // Reference model: resident ops kept oldest first.
    typedef struct {
        iss_bundle_t b;
        logic [1:0]  busy;
    } ment_t;
    ment_t       mq[$];
    logic [RWD-1:0] exp_ready;
    iss_bundle_t exp_iss [PWD];
    int          exp_sel [PWD];

    function automatic logic m_wake(input logic [5:0] a);
        for (int k = 0; k < EWD; k++) begin
            if (bus.exe_bundle[k].opid[15] && bus.exe_bundle[k].prda == a) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic logic ent_ready(input ment_t m, input int p);
        logic b0, b1;
        b0 = m.busy[0] && !m_wake(m.b.prsa[0]);
        b1 = m.busy[1] && !m_wake(m.b.prsa[1]);
        return !b0 && !b1 && ((m.b.fu & pfu[p] & bus.fu_ready) != 5'b0);
    endfunction

    function automatic void model_calc();
        int   room;
        logic ok, taken;
        exp_ready = '0;
        for (int p = 0; p < PWD; p++) begin
            exp_iss[p] = '0;
            exp_sel[p] = -1;
        end
        if (rst || bus.redir) return;
        room = IQSZ - mq.size();
        ok   = 1'b1;
        for (int l = 0; l < RWD; l++) begin
            ok = ok && bus.ren_bundle[l].opid[15] && (l < room);
            exp_ready[l] = ok;
        end
        for (int p = 0; p < PWD; p++) begin
            for (int k = 0; k < mq.size(); k++) begin
                taken = 1'b0;
                for (int q = 0; q < p; q++) if (exp_sel[q] == k) taken = 1'b1;
                if (!taken && exp_sel[p] < 0 && ent_ready(mq[k], p)) begin
                    exp_sel[p] = k;
                    exp_iss[p] = mq[k].b;
                end
            end
        end
    endfunction

    function automatic void model_commit();
        ment_t nq[$];
        ment_t e;
        logic  drop;
        if (rst || bus.redir) begin
            mq.delete();
            return;
        end
        for (int k = 0; k < mq.size(); k++) begin
            drop = 1'b0;
            for (int p = 0; p < PWD; p++) if (exp_sel[p] == k && bus.issue[p]) drop = 1'b1;
            if (!drop) begin
                e = mq[k];
                for (int s = 0; s < 2; s++) if (m_wake(e.b.prsa[s])) e.busy[s] = 1'b0;
                nq.push_back(e);
            end
        end
        for (int l = 0; l < RWD; l++) begin
            if (exp_ready[l]) begin
                e.b    = bus.ren_bundle[l];
                e.busy = bus.busy_resp[l];
                for (int s = 0; s < 2; s++) if (m_wake(e.b.prsa[s])) e.busy[s] = 1'b0;
                nq.push_back(e);
            end
        end
        mq = nq;
    endfunction

    task automatic tick();
        model_calc();
        model_commit();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_inputs();
        bus.redir      = 1'b0;
        bus.fu_ready   = 5'b11111;
        bus.exe_bundle = '0;
        bus.ren_bundle = '0;
        bus.busy_resp  = '0;
        bus.issue      = '0;
    endtask

    function automatic iss_bundle_t mk(input int id, input fu_t fu,
                                       input logic [5:0] s0, input logic [5:0] s1);
        iss_bundle_t b;
        b.opid    = 16'h8000 | 16'(id);
        b.fu      = fu;
        b.prsa[0] = s0;
        b.prsa[1] = s1;
        b.prda    = 6'(id);
        return b;
    endfunction

    task automatic test_reset();
        clear_inputs();
        rst = 1'b1;
        bus.ren_bundle[0] = mk(1, ALU, 0, 0);
        bus.issue = '1;
        @(posedge clk);
        #3;
        n_cmp++;
        if (bus.ready !== 4'b0) begin
            n_fail++; $display("FAIL reset_ready: got %b want 0000", bus.ready);
        end
        n_cmp++;
        if (bus.iss_bundle !== '0) begin
            n_fail++; $display("FAIL reset_iss: got %h want 0", bus.iss_bundle);
        end
        tick();
        rst = 1'b0;
        clear_inputs();
        mq.delete();
        #1;
        n_cmp++;
        if (bus.count !== 5'd0) begin
            n_fail++; $display("FAIL reset_count: got %0d want 0", bus.count);
        end
    endtask

    task automatic test_enq_issue();
        clear_inputs();
        for (int l = 0; l < 4; l++) bus.ren_bundle[l] = mk(10 + l, ALU, 1, 2);
        #1;
        n_cmp++;
        if (bus.ready !== 4'b1111) begin
            n_fail++; $display("FAIL enq_ready: got %b want 1111", bus.ready);
        end
        n_cmp++;
        if (bus.iss_bundle !== '0) begin
            n_fail++; $display("FAIL enq_same_cycle_iss: got %h want 0", bus.iss_bundle);
        end
        tick();
        clear_inputs();
        bus.issue = 3'b111;
        #1;
        n_cmp++;
        if (bus.iss_bundle[0] !== mk(10, ALU, 1, 2) || bus.iss_bundle[1] !== mk(11, ALU, 1, 2)
            || bus.iss_bundle[2] !== '0) begin
            n_fail++; $display("FAIL enq_select: got %h want %h/%h/0", bus.iss_bundle,
                               mk(11, ALU, 1, 2), mk(10, ALU, 1, 2));
        end
        n_cmp++;
        if (bus.count !== 5'd4) begin
            n_fail++; $display("FAIL enq_count4: got %0d want 4", bus.count);
        end
        tick();
        n_cmp++;
        if (bus.count !== 5'd2 || bus.iss_bundle[0] !== mk(12, ALU, 1, 2)) begin
            n_fail++; $display("FAIL enq_count2: got %0d %h want 2 %h", bus.count,
                               bus.iss_bundle[0], mk(12, ALU, 1, 2));
        end
        tick();
        clear_inputs();
        #1;
    endtask

    task automatic test_full();
        clear_inputs();
        for (int c = 0; c < 4; c++) begin
            for (int l = 0; l < 4; l++) bus.ren_bundle[l] = mk(100 + 4 * c + l, LSU, 0, 0);
            #1;
            tick();
        end
        clear_inputs();
        bus.ren_bundle[0] = mk(200, ALU, 0, 0);
        bus.ren_bundle[1] = mk(201, ALU, 0, 0);
        bus.issue = 3'b100;
        #1;
        n_cmp++;
        if (bus.ready !== 4'b0000 || bus.count !== 5'd16) begin
            n_fail++; $display("FAIL full_ready: got %b cnt %0d want 0000 cnt 16",
                               bus.ready, bus.count);
        end
        n_cmp++;
        if (bus.iss_bundle[2] !== mk(100, LSU, 0, 0)) begin
            n_fail++; $display("FAIL full_select: got %h want %h", bus.iss_bundle[2],
                               mk(100, LSU, 0, 0));
        end
        tick();
        bus.issue = '0;
        #1;
        n_cmp++;
        if (bus.ready !== 4'b0001 || bus.count !== 5'd15) begin
            n_fail++; $display("FAIL full_one_free: got %b cnt %0d want 0001 cnt 15",
                               bus.ready, bus.count);
        end
        tick();
        n_cmp++;
        if (bus.ready !== 4'b0000 || bus.count !== 5'd16) begin
            n_fail++; $display("FAIL full_again: got %b cnt %0d want 0000 cnt 16",
                               bus.ready, bus.count);
        end
        clear_inputs();
        bus.redir = 1'b1;
        #1;
        tick();
        clear_inputs();
        #1;
    endtask

    task automatic test_wakeup();
        clear_inputs();
        bus.ren_bundle[0] = mk(300, ALU, 7, 9);
        bus.busy_resp[0]  = 2'b01;
        #1;
        tick();
        clear_inputs();
        #1;
        n_cmp++;
        if (bus.iss_bundle[0] !== '0 || bus.count !== 5'd1) begin
            n_fail++; $display("FAIL wake_blocked: got %h cnt %0d want 0 cnt 1",
                               bus.iss_bundle[0], bus.count);
        end
        bus.exe_bundle[2].opid = 16'h8032;
        bus.exe_bundle[2].prda = 6'd7;
        #1;
        n_cmp++;
        if (bus.iss_bundle[0] !== mk(300, ALU, 7, 9)) begin
            n_fail++; $display("FAIL wake_same_cycle: got %h want %h", bus.iss_bundle[0],
                               mk(300, ALU, 7, 9));
        end
        bus.issue = 3'b001;
        tick();
        clear_inputs();
        bus.ren_bundle[0] = mk(301, ALU, 3, 12);
        bus.busy_resp[0]  = 2'b10;
        bus.exe_bundle[1].opid = 16'h8033;
        bus.exe_bundle[1].prda = 6'd12;
        #1;
        tick();
        clear_inputs();
        #1;
        n_cmp++;
        if (bus.iss_bundle[0] !== mk(301, ALU, 3, 12) || bus.count !== 5'd1) begin
            n_fail++; $display("FAIL wake_at_enqueue: got %h cnt %0d want %h cnt 1",
                               bus.iss_bundle[0], bus.count, mk(301, ALU, 3, 12));
        end
        bus.issue = 3'b001;
        tick();
        clear_inputs();
        #1;
    endtask

    task automatic test_age();
        clear_inputs();
        bus.ren_bundle[0] = mk(400, ALU, 0, 0);
        bus.ren_bundle[1] = mk(401, LSU, 0, 0);
        #1;
        tick();
        clear_inputs();
        bus.issue = 3'b001;
        #1;
        n_cmp++;
        if (bus.iss_bundle[0] !== mk(400, ALU, 0, 0)) begin
            n_fail++; $display("FAIL age_first: got %h want %h", bus.iss_bundle[0],
                               mk(400, ALU, 0, 0));
        end
        tick();
        clear_inputs();
        bus.ren_bundle[0] = mk(402, LSU, 0, 0);
        #1;
        n_cmp++;
        if (bus.ready !== 4'b0001 || bus.iss_bundle[2] !== mk(401, LSU, 0, 0)) begin
            n_fail++; $display("FAIL age_enq_b: got %b %h want 0001 %h", bus.ready,
                               bus.iss_bundle[2], mk(401, LSU, 0, 0));
        end
        tick();
        clear_inputs();
        bus.issue = 3'b100;
        #1;
        n_cmp++;
        if (bus.iss_bundle[2] !== mk(401, LSU, 0, 0)) begin
            n_fail++; $display("FAIL age_a_older: got %h want %h", bus.iss_bundle[2],
                               mk(401, LSU, 0, 0));
        end
        tick();
        #1;
        n_cmp++;
        if (bus.iss_bundle[2] !== mk(402, LSU, 0, 0)) begin
            n_fail++; $display("FAIL age_b_next: got %h want %h", bus.iss_bundle[2],
                               mk(402, LSU, 0, 0));
        end
        tick();
        clear_inputs();
        #1;
        n_cmp++;
        if (bus.count !== 5'd0) begin
            n_fail++; $display("FAIL age_drain: got %0d want 0", bus.count);
        end
    endtask

    task automatic test_hold();
        clear_inputs();
        bus.ren_bundle[0] = mk(500, ALU, 4, 5);
        #1;
        tick();
        clear_inputs();
        for (int i = 0; i < 3; i++) begin
            #1;
            n_cmp++;
            if (bus.iss_bundle[0] !== mk(500, ALU, 4, 5) || bus.count !== 5'd1) begin
                n_fail++; $display("FAIL hold_cycle%0d: got %h cnt %0d want %h cnt 1", i,
                                   bus.iss_bundle[0], bus.count, mk(500, ALU, 4, 5));
            end
            tick();
        end
        bus.issue = 3'b001;
        tick();
        clear_inputs();
        #1;
        n_cmp++;
        if (bus.count !== 5'd0) begin
            n_fail++; $display("FAIL hold_release: got %0d want 0", bus.count);
        end
    endtask

    task automatic test_redir();
        clear_inputs();
        for (int c = 0; c < 3; c++) begin
            bus.ren_bundle = '0;
            for (int l = 0; l < 4; l++) begin
                if (4 * c + l < 9) bus.ren_bundle[l] = mk(600 + 4 * c + l, MUL, 0, 0);
            end
            #1;
            tick();
        end
        clear_inputs();
        #1;
        n_cmp++;
        if (bus.count !== 5'd9) begin
            n_fail++; $display("FAIL redir_pre_count: got %0d want 9", bus.count);
        end
        bus.redir = 1'b1;
        bus.ren_bundle[0] = mk(700, ALU, 0, 0);
        bus.ren_bundle[1] = mk(701, ALU, 0, 0);
        #1;
        n_cmp++;
        if (bus.ready !== 4'b0 || bus.iss_bundle !== '0) begin
            n_fail++; $display("FAIL redir_outputs: got %b %h want 0000 0", bus.ready,
                               bus.iss_bundle);
        end
        tick();
        clear_inputs();
        #1;
        n_cmp++;
        if (bus.count !== 5'd0 || bus.iss_bundle !== '0) begin
            n_fail++; $display("FAIL redir_flush: got cnt %0d %h want 0 0", bus.count,
                               bus.iss_bundle);
        end
    endtask

    task automatic test_random();
        int r;
        iss_bundle_t b;
        clear_inputs();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            bus.redir    = ($urandom_range(0, 59) == 0);
            bus.fu_ready = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'b11111;
            bus.issue    = 3'($urandom) | 3'($urandom);
            for (int k = 0; k < EWD; k++) begin
                bus.exe_bundle[k].opid = {1'($urandom), 15'($urandom)};
                bus.exe_bundle[k].prda = 6'($urandom_range(0, 15));
            end
            for (int l = 0; l < RWD; l++) begin
                r = $urandom_range(0, 15);
                b = mk(opid_n, (r == 0) ? MUL : ((r < 9) ? ALU : LSU),
                       6'($urandom_range(0, 15)), 6'($urandom_range(0, 15)));
                opid_n = (opid_n + 1) & 16'h3fff;
                b.opid[15] = ($urandom_range(0, 9) < 8);
                bus.ren_bundle[l] = b;
                bus.busy_resp[l]  = {($urandom_range(0, 9) < 3), ($urandom_range(0, 9) < 3)};
            end
            #1;
            model_calc();
            n_cmp++;
            if (bus.ready !== exp_ready) begin
                n_fail++; $display("FAIL rnd_ready @%0d: got %b want %b", cyc, bus.ready,
                                   exp_ready);
            end
            for (int p = 0; p < PWD; p++) begin
                n_cmp++;
                if (bus.iss_bundle[p] !== exp_iss[p]) begin
                    n_fail++; $display("FAIL rnd_iss%0d @%0d: got %h want %h", p, cyc,
                                       bus.iss_bundle[p], exp_iss[p]);
                end
            end
            n_cmp++;
            if (bus.count !== 5'(mq.size())) begin
                n_fail++; $display("FAIL rnd_count @%0d: got %0d want %0d", cyc, bus.count,
                                   mq.size());
            end
            tick();
        end
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_enq_issue();
        test_full();
        test_wakeup();
        test_age();
        test_hold();
        test_redir();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end
endmodule
